// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit
//
// Multicycle radix-2 shift-add multiplier for the multicycle ARM datapath.
// One multiplier bit is consumed per cycle, which keeps the wide multiply
// off the ALU critical path. The controller raises start while ready=1 and
// then stalls until done.
//
// Operations (op, sampled with start):
//   2'b00 MUL   : result_lo = (a*b)[WIDTH-1:0],      result_hi = 0
//   2'b01 MLA   : result_lo = (a*b + c)[WIDTH-1:0],  result_hi = 0
//   2'b10 UMULL : {result_hi, result_lo} = a*b       (unsigned)
//   2'b11 SMULL : {result_hi, result_lo} = a*b       (signed)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, priority over everything
//   start      in   operation request, accepted only in IDLE
//   op         in   operation select
//   a, b, c    in   multiplicand, multiplier, MLA accumulator
//   ready      out  high in IDLE
//   busy       out  high in RUN and FIX
//   done       out  one-cycle completion pulse
//   result_lo  out  low half of the result
//   result_hi  out  high half of the result (0 for MUL/MLA)
//   flags      out  {N, Z}, held until the next operation's FIX
//
// Timing: start sampled at edge t0, WIDTH RUN cycles, one FIX cycle, then
// done is high for one cycle and is seen by the clock edge t0+WIDTH+2.
// The earliest following start is sampled at edge t0+WIDTH+3.
// ---------------------------------------------------------------------------
module mul_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags
);

    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MLA   = 2'b01;
    localparam logic [1:0] OP_UMULL = 2'b10;
    localparam logic [1:0] OP_SMULL = 2'b11;

    localparam logic [PW-1:0]    PW_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0]    PW_ONE    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Unsigned magnitude of a two's complement value. The most negative
    // value maps onto 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = ~v + W_ONE;
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t            state_r;
    state_t            state_next_s;

    logic [1:0]        op_r;
    logic [PW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [WIDTH-1:0]  c_r;
    logic              neg_r;
    logic [PW-1:0]     acc_r;
    logic [CNT_W-1:0]  count_r;

    logic [WIDTH-1:0]  result_lo_r;
    logic [WIDTH-1:0]  result_hi_r;
    logic [1:0]        flags_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;

    logic [PW-1:0]     sum_s;
    logic [PW-1:0]     prod_s;
    logic [WIDTH-1:0]  fix_lo_s;
    logic [WIDTH-1:0]  fix_hi_s;
    logic              fix_n_s;
    logic              fix_z_s;

    // Next-state logic of the control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == CNT_ZERO) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // One shift-add step: add the aligned multiplicand when the current
    // multiplier bit is set.
    always_comb begin
        sum_s = acc_r;
        if (mplier_r[0]) begin
            sum_s = acc_r + mcand_r;
        end else begin
            sum_s = acc_r;
        end
    end

    // Final product, result halves and {N, Z} computed during FIX.
    always_comb begin
        prod_s   = acc_r;
        fix_lo_s = W_ZERO;
        fix_hi_s = W_ZERO;
        fix_n_s  = 1'b0;
        fix_z_s  = 1'b0;

        // neg_r is only ever set for SMULL, so this is a no-op otherwise.
        if (neg_r) begin
            prod_s = ~acc_r + PW_ONE;
        end else begin
            prod_s = acc_r;
        end

        case (op_r)
            OP_MUL: begin
                fix_lo_s = acc_r[WIDTH-1:0];
                fix_hi_s = W_ZERO;
            end
            OP_MLA: begin
                // Accumulate wraps modulo 2^WIDTH, carry-out discarded.
                fix_lo_s = acc_r[WIDTH-1:0] + c_r;
                fix_hi_s = W_ZERO;
            end
            OP_UMULL, OP_SMULL: begin
                fix_lo_s = prod_s[WIDTH-1:0];
                fix_hi_s = prod_s[PW-1:WIDTH];
            end
            default: begin
                fix_lo_s = W_ZERO;
                fix_hi_s = W_ZERO;
            end
        endcase

        // Long ops judge N and Z on the full 2*WIDTH result.
        if (op_r[1]) begin
            fix_n_s = fix_hi_s[WIDTH-1];
            fix_z_s = ({fix_hi_s, fix_lo_s} == PW_ZERO);
        end else begin
            fix_n_s = fix_lo_s[WIDTH-1];
            fix_z_s = (fix_lo_s == W_ZERO);
        end
    end

    // State register, operand/iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_MUL;
            mcand_r     <= PW_ZERO;
            mplier_r    <= W_ZERO;
            c_r         <= W_ZERO;
            neg_r       <= 1'b0;
            acc_r       <= PW_ZERO;
            count_r     <= CNT_ZERO;
            result_lo_r <= W_ZERO;
            result_hi_r <= W_ZERO;
            flags_r     <= 2'b00;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_FIX);
            done_r  <= (state_next_s == ST_DONE);

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        c_r     <= c;
                        acc_r   <= PW_ZERO;
                        count_r <= CNT_START;
                        if (op == OP_SMULL) begin
                            // Multiply magnitudes, restore the sign in FIX.
                            mcand_r  <= {W_ZERO, magnitude(a)};
                            mplier_r <= magnitude(b);
                            neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
                        end else begin
                            mcand_r  <= {W_ZERO, a};
                            mplier_r <= b;
                            neg_r    <= 1'b0;
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_RUN: begin
                    acc_r    <= sum_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    if (count_r != CNT_ZERO) begin
                        count_r <= count_r - CNT_ONE;
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_FIX: begin
                    result_lo_r <= fix_lo_s;
                    result_hi_r <= fix_hi_s;
                    flags_r     <= {fix_n_s, fix_z_s};
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result_lo = result_lo_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_mul_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_unit
//
// Scoreboard bench for mul_unit. Two instances are exercised: WIDTH=32 with
// hand-computed directed vectors (including the mid-RUN ignored start and
// mid-RUN reset cases) and WIDTH=8 with hand-computed corner vectors plus a
// short random sweep checked against an arithmetic reference model.
// Stimulus pushes the expected response into a per-instance queue; a monitor
// per instance pops and compares whenever done is high, including the
// start-to-done latency.
// ---------------------------------------------------------------------------
module tb_mul_unit;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] fl;
        int          t0;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32;
    exp_t e8;

    // WIDTH=32 instance
    logic        r32_reset, r32_start, r32_ready, r32_busy, r32_done;
    logic [1:0]  r32_op, r32_flags;
    logic [31:0] r32_a, r32_b, r32_c, r32_lo, r32_hi;

    // WIDTH=8 instance
    logic        r8_reset, r8_start, r8_ready, r8_busy, r8_done;
    logic [1:0]  r8_op, r8_flags;
    logic [7:0]  r8_a, r8_b, r8_c, r8_lo, r8_hi;

    mul_unit #(.WIDTH(32)) u_mul32 (
        .clk(clk), .reset(r32_reset), .start(r32_start), .op(r32_op),
        .a(r32_a), .b(r32_b), .c(r32_c),
        .ready(r32_ready), .busy(r32_busy), .done(r32_done),
        .result_lo(r32_lo), .result_hi(r32_hi), .flags(r32_flags)
    );

    mul_unit #(.WIDTH(8)) u_mul8 (
        .clk(clk), .reset(r8_reset), .start(r8_start), .op(r8_op),
        .a(r8_a), .b(r8_b), .c(r8_c),
        .ready(r8_ready), .busy(r8_busy), .done(r8_done),
        .result_lo(r8_lo), .result_hi(r8_hi), .flags(r8_flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (r32_done === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                $display("FAIL spurious_done32: done high with nothing pending at cycle %0d", cyc);
            end else begin
                e32 = q32.pop_front();
                check({e32.name, "_lo"}, {32'h0, r32_lo}, e32.lo);
                check({e32.name, "_hi"}, {32'h0, r32_hi}, e32.hi);
                check({e32.name, "_flags"}, {62'h0, r32_flags}, e32.fl);
                check({e32.name, "_latency"}, 64'(cyc + 1 - e32.t0), 64'd34);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (r8_done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                $display("FAIL spurious_done8: done high with nothing pending at cycle %0d", cyc);
            end else begin
                e8 = q8.pop_front();
                check({e8.name, "_lo"}, {56'h0, r8_lo}, e8.lo);
                check({e8.name, "_hi"}, {56'h0, r8_hi}, e8.hi);
                check({e8.name, "_flags"}, {62'h0, r8_flags}, e8.fl);
                check({e8.name, "_latency"}, 64'(cyc + 1 - e8.t0), 64'd10);
            end
        end
    end

    task automatic send32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] lo, input logic [31:0] hi,
                          input logic [1:0] fl, input string name, input bit push,
                          output int t0);
        exp_t e;
        @(negedge clk);
        r32_op = op; r32_a = a; r32_b = b; r32_c = c; r32_start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        e.lo = {32'h0, lo}; e.hi = {32'h0, hi}; e.fl = {62'h0, fl};
        e.t0 = t0; e.name = name;
        if (push) q32.push_back(e);
        @(negedge clk);
        // Scramble operands: the DUT must have latched them already.
        r32_start = 1'b0;
        r32_a = $urandom; r32_b = $urandom; r32_c = $urandom; r32_op = 2'($urandom);
    endtask

    task automatic wait32();
        for (int i = 0; i < 100 && q32.size() != 0; i++) @(negedge clk);
        if (q32.size() != 0) begin
            checks++;
            $display("FAIL timeout32: %0d results still pending", q32.size());
            q32.delete();
        end
        for (int i = 0; i < 10 && r32_ready !== 1'b1; i++) @(negedge clk);
        check("ready32_after_done", {63'h0, r32_ready}, 64'h1);
    endtask

    task automatic send8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [1:0] fl, input string name);
        exp_t e;
        @(negedge clk);
        r8_op = op; r8_a = a; r8_b = b; r8_c = c; r8_start = 1'b1;
        @(posedge clk);
        #1;
        e.lo = {56'h0, lo}; e.hi = {56'h0, hi}; e.fl = {62'h0, fl};
        e.t0 = cyc; e.name = name;
        q8.push_back(e);
        @(negedge clk);
        r8_start = 1'b0;
        r8_a = 8'($urandom); r8_b = 8'($urandom); r8_c = 8'($urandom); r8_op = 2'($urandom);
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            checks++;
            $display("FAIL timeout8_%s: result never presented", name);
            q8.delete();
        end
        for (int i = 0; i < 10 && r8_ready !== 1'b1; i++) @(negedge clk);
    endtask

    // Arithmetic reference for the 8-bit sweep (uses plain integer multiply).
    function automatic void ref8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, output logic [7:0] lo,
                                 output logic [7:0] hi, output logic [1:0] fl);
        int sa, sb;
        logic [31:0] p;
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        case (op)
            2'b00:   begin p = 32'(int'(a) * int'(b));           lo = p[7:0]; hi = 8'h00; end
            2'b01:   begin p = 32'(int'(a) * int'(b) + int'(c)); lo = p[7:0]; hi = 8'h00; end
            2'b10:   begin p = 32'(int'(a) * int'(b));           lo = p[7:0]; hi = p[15:8]; end
            default: begin p = 32'(sa * sb);                     lo = p[7:0]; hi = p[15:8]; end
        endcase
        fl[1] = op[1] ? hi[7] : lo[7];
        fl[0] = ({hi, lo} == 16'h0000);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic [1:0] rop, rfl;
        logic [7:0] ra, rb, rc, rlo, rhi;

        r32_reset = 1'b1; r32_start = 1'b0; r32_op = 2'b00;
        r32_a = 32'h0; r32_b = 32'h0; r32_c = 32'h0;
        r8_reset = 1'b1; r8_start = 1'b0; r8_op = 2'b00;
        r8_a = 8'h0; r8_b = 8'h0; r8_c = 8'h0;
        repeat (3) @(negedge clk);
        r32_reset = 1'b0; r8_reset = 1'b0;
        @(negedge clk);

        check("reset_ready32", {63'h0, r32_ready}, 64'h1);
        check("reset_busy32",  {63'h0, r32_busy},  64'h0);
        check("reset_done32",  {63'h0, r32_done},  64'h0);
        check("reset_lo32",    {32'h0, r32_lo},    64'h0);
        check("reset_hi32",    {32'h0, r32_hi},    64'h0);
        check("reset_flags32", {62'h0, r32_flags}, 64'h0);
        check("reset_ready8",  {63'h0, r8_ready},  64'h1);

        // 32-bit directed vectors
        send32(2'b11, 32'hFFFFFFFD, 32'h5, 32'h0, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10, "smull_m3x5", 1'b1, t0);
        wait32();
        send32(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'hFFFFFFFE, 2'b10, "umull_max", 1'b1, t0);
        wait32();
        send32(2'b11, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 2'b00, "smull_minsq", 1'b1, t0);
        wait32();
        send32(2'b01, 32'h7, 32'h6, 32'd100, 32'h8E, 32'h0, 2'b00, "mla_7x6p100", 1'b1, t0);
        wait32();
        send32(2'b01, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h0, 2'b01, "mla_wrap", 1'b1, t0);
        wait32();
        send32(2'b10, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 2'b01, "umull_zero", 1'b1, t0);
        wait32();

        // MUL with an ignored start pulse during RUN
        send32(2'b00, 32'h10000, 32'h10000, 32'h0, 32'h0, 32'h0, 2'b01, "mul_2p32", 1'b1, t0);
        while (cyc < t0 + 4) @(negedge clk);
        r32_op = 2'b00; r32_a = 32'h3; r32_b = 32'h4; r32_start = 1'b1;
        check("run_busy32",  {63'h0, r32_busy},  64'h1);
        check("run_ready32", {63'h0, r32_ready}, 64'h0);
        @(negedge clk);
        r32_start = 1'b0;
        wait32();

        send32(2'b00, 32'h80000000, 32'h1, 32'h55, 32'h80000000, 32'h0, 2'b10, "mul_neg", 1'b1, t0);
        wait32();

        // Reset mid-RUN: the in-flight op must never signal done
        send32(2'b00, 32'h5, 32'h5, 32'h0, 32'h19, 32'h0, 2'b00, "mul_aborted", 1'b0, t0);
        while (cyc < t0 + 9) @(negedge clk);
        r32_reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_ready32", {63'h0, r32_ready}, 64'h1);
        check("midreset_busy32",  {63'h0, r32_busy},  64'h0);
        check("midreset_done32",  {63'h0, r32_done},  64'h0);
        check("midreset_lo32",    {32'h0, r32_lo},    64'h0);
        check("midreset_hi32",    {32'h0, r32_hi},    64'h0);
        check("midreset_flags32", {62'h0, r32_flags}, 64'h0);
        @(negedge clk);
        r32_reset = 1'b0;
        repeat (40) @(negedge clk);
        send32(2'b00, 32'h3, 32'h4, 32'd999, 32'd12, 32'h0, 2'b00, "mul_3x4", 1'b1, t0);
        wait32();

        // 8-bit hand-computed corner vectors
        send8(2'b11, 8'h80, 8'h80, 8'h00, 8'h00, 8'h40, 2'b00, "w8_smull_minsq");
        send8(2'b11, 8'h7F, 8'h80, 8'h00, 8'h80, 8'hC0, 2'b10, "w8_smull_maxmin");
        send8(2'b10, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFE, 2'b10, "w8_umull_max");
        send8(2'b01, 8'd200, 8'd3, 8'd100, 8'hBC, 8'h00, 2'b10, "w8_mla_wrap");
        send8(2'b00, 8'd16, 8'd16, 8'h00, 8'h00, 8'h00, 2'b01, "w8_mul_zero");
        send8(2'b11, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF, 2'b10, "w8_smull_m1");

        // 8-bit random sweep against the reference model
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom); ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
            ref8(rop, ra, rb, rc, rlo, rhi, rfl);
            send8(rop, ra, rb, rc, rlo, rhi, rfl, $sformatf("w8_rand%0d", i));
        end

        repeat (4) @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'h0);
        check("q8_drained",  64'(q8.size()),  64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Parametrised multicycle multiplier for the multicycle ARM datapath; successor to the single-cycle ALU multiply paths.
- Supports MUL, MLA (multiply-accumulate), UMULL and SMULL.
- Uses a radix-2 shift-add iteration, one product bit per cycle, with a start/done handshake, so the wide multiply is removed from the ALU critical path.
- The controller FSM issues `start` and stalls until `done`.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits. Legal values are 4 to 64.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- op  input  2  operation, sampled with start: 00 MUL, 01 MLA, 10 UMULL, 11 SMULL
- a  input  WIDTH  multiplicand (Rn/Rm), sampled with start
- b  input  WIDTH  multiplier, sampled with start
- c  input  WIDTH  accumulator for MLA, sampled with start; ignored for other ops
- ready  output  1  high in IDLE
- busy  output  1  high in RUN and FIX
- done  output  1  single-cycle completion pulse
- result_lo  output  WIDTH  low half of the result
- result_hi  output  WIDTH  high half of the result; 0 for MUL and MLA
- flags  output  2  {N, Z}, valid from done onward

Behaviour:
- Reset: synchronous; has priority over all other inputs, including mid-operation.
  - State goes to IDLE.
  - ready=1, busy=0, done=0, result_lo=0, result_hi=0, flags=0.
  - Any in-flight operation is discarded; done is never asserted for it.
- States: IDLE, RUN, FIX, DONE.
- IDLE: when start=1, latch op, a, b and c.
  - For SMULL, latch |a| and |b| as WIDTH-bit unsigned magnitudes and record neg = a[MSB]^b[MSB]. The magnitude of the most negative value is 2^(WIDTH-1), representable unsigned.
  - For all other ops, latch the raw operands with neg=0.
  - Clear the 2*WIDTH accumulator, set count=WIDTH-1 and go to RUN.
  - When start=0, stay in IDLE.
- RUN: each cycle, if the multiplier LSB is 1, add the shifted multiplicand into the accumulator. Then shift the multiplier right and the multiplicand left.
  - When count=0, go to FIX; otherwise decrement count.
  - Total: exactly WIDTH cycles in RUN.
- FIX: one cycle that computes the final product.
  - SMULL: product = neg ? -acc : acc (2*WIDTH two's complement).
  - MLA: result_lo = acc[WIDTH-1:0] + c, modulo 2^WIDTH, no carry-out. result_hi=0.
  - MUL: result_lo = acc[WIDTH-1:0]. result_hi=0.
  - UMULL/SMULL: {result_hi, result_lo} = product.
  - Register flags:
    - N = result_hi[MSB] for UMULL/SMULL, result_lo[MSB] for MUL/MLA.
    - Z = 1 if all relevant result bits are zero (2*WIDTH bits for long ops, WIDTH bits otherwise).
  - Next state is DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start is sampled at edge t0. done=1 between edges t0+WIDTH+2 and t0+WIDTH+3. Minimum start-to-start spacing is WIDTH+3 cycles.
- Result hold: result_lo, result_hi and flags change only in FIX or on reset. They hold their values through DONE and IDLE until the next operation's FIX.
- start while not in IDLE (RUN, FIX or DONE) is ignored and not queued. Inputs a, b, c and op may change freely after they are sampled.
- No C or V flag is produced. The controller preserves those flags, matching ARM MUL semantics.

Test Plan:
- SMULL, a=0xFFFFFFFD (-3), b=5 -> done at t0+34; result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, flags N=1 Z=0.
- UMULL, a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, N=1. Also SMULL with a=b=0x80000000 -> result_hi=0x40000000, result_lo=0, N=0 Z=0.
- MLA, a=7, b=6, c=100 -> result_lo=0x8E, result_hi=0. Also MLA a=0xFFFFFFFF, b=1, c=1 -> result_lo=0, Z=1 (wrap).
- MUL, a=0x10000, b=0x10000 -> result_lo=0, result_hi=0, Z=1, N=0. Then pulse start with new operands at t0+5 (during RUN) -> ignored; done occurs once, at t0+34, with the original result.
- Assert reset at t0+10 mid-RUN -> the next cycle shows ready=1, busy=0, results 0, and done never pulses. A following MUL 3*4 completes correctly with result_lo=12.
- Sweep WIDTH=8 with random a, b, op against a behavioural reference model -> done at exactly t0+WIDTH+2 and every result bit-exact.
